// File: rtl/seq_det_sched.sv
// seq_det_sched: four serial bit channels share one 11001 overlapping Mealy
//   detector; a round-robin arbiter picks which channel's bit is consumed.
// Latency: grant is combinational; det_valid/det_ch register one cycle after
//   the completing bit is consumed. cnt_out reads the registered counters.
// Backpressure: a channel whose req is not granted keeps its bit; the
//   requester holds req/din until grant[i] rises.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req, din        per-channel bit request and data bit (bit i = channel i)
//   chan_en         enable mask; disabled channels are never granted
//   clr_ch          per-channel synchronous clear of state and counter
//   grant           one-hot ack, the granted channel's din is consumed
//   det_valid/ch    one-cycle detection pulse and the detecting channel
//   cnt_sel/cnt_out read port for the saturating per-channel match counters
module seq_det_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       din,
  input  logic [3:0]       chan_en,
  input  logic [3:0]       clr_ch,
  output logic [3:0]       grant,
  output logic             det_valid,
  output logic [1:0]       det_ch,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4   // "1100"
  } st_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  st_t              state [4];
  logic [CNT_W-1:0] cnt   [4];
  logic [1:0]       rr_ptr;

  logic [3:0] eligible;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  st_t        cur_st;
  logic       cur_bit;
  st_t        nxt_st;
  logic       hit;

  assign eligible = req & chan_en;

  // Round-robin: first eligible channel at or after rr_ptr, wrapping 3->0.
  // Nothing is granted while reset is held, so no bit is lost to reset.
  always_comb begin
    logic [1:0] idx;
    grant   = 4'b0000;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int o = 0; o < 4; o++) begin
      idx = rr_ptr + 2'(o);
      if (!gnt_any && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (reset) begin
      gnt_any = 1'b0;
    end
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Single shared next-state/detect function, fed by the granted channel.
  always_comb begin
    cur_st  = state[gnt_idx];
    cur_bit = din[gnt_idx];
    nxt_st  = S0;
    hit     = 1'b0;
    case (cur_st)
      S0: nxt_st = cur_bit ? S1 : S0;
      S1: nxt_st = cur_bit ? S2 : S0;
      S2: nxt_st = cur_bit ? S2 : S3;
      S3: nxt_st = cur_bit ? S1 : S4;
      S4: begin
        // Completing 1 leaves "1" matched, which is the overlap restart.
        nxt_st = cur_bit ? S1 : S0;
        hit    = cur_bit;
      end
      default: nxt_st = S0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= S0;
        cnt[i]   <= '0;
      end
      rr_ptr    <= 2'd0;
      det_valid <= 1'b0;
      det_ch    <= 2'd0;
    end else begin
      // A clear on the granted channel still consumes the bit (grant is up)
      // but suppresses both the state advance and any detection.
      det_valid <= gnt_any && hit && !clr_ch[gnt_idx];
      if (gnt_any && hit && !clr_ch[gnt_idx]) begin
        det_ch <= gnt_idx;
      end
      if (gnt_any) begin
        rr_ptr <= gnt_idx + 2'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (clr_ch[i]) begin
          state[i] <= S0;
          cnt[i]   <= '0;
        end else if (grant[i]) begin
          state[i] <= nxt_st;
          if (hit && cnt[i] != CNT_MAX) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Registered counters only: a same-cycle increment shows up next cycle.
  assign cnt_out = cnt[cnt_sel];

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of each per-channel saturating match counter.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  4  per-channel bit-valid request, bit i = channel i.
REQ-005 SHALL have port: din  input  4  per-channel serial data bit, sampled with req[i].
REQ-006 SHALL have port: chan_en  input  4  channel enable mask; disabled channel requests ignored.
REQ-007 SHALL have port: clr_ch  input  4  per-channel synchronous clear pulse (state and counter).
REQ-008 SHALL have port: grant  output  4  one-hot combinational ack; din of granted channel consumed this cycle.
REQ-009 SHALL have port: det_valid  output  1  registered pulse, 11001 detected on det_ch.
REQ-010 SHALL have port: det_ch  output  2  channel index of detection, valid with det_valid.
REQ-011 SHALL have port: cnt_sel  input  2  counter read select.
REQ-012 SHALL have port: cnt_out  output  CNT_W  combinational read of counter[cnt_sel].

Function
REQ-013 SHALL share one 11001 overlapping Mealy next-state/detect function among 4 channels, with a 3-bit saved state per channel.
REQ-014 SHALL encode channel states S0 (none), S1 ("1"), S2 ("11"), S3 ("110"), S4 ("1100").
REQ-015 SHALL transition: S0 -1->S1, -0->S0; S1 -1->S2, -0->S0; S2 -1->S2, -0->S3; S3 -0->S4, -1->S1; S4 -1->S1 with detect, -0->S0.
REQ-016 SHALL update only the granted channel's state per cycle; ungranted channels hold state.
REQ-017 SHALL form eligible = req & chan_en and grant at most one eligible channel per cycle; grant = 0 when eligible = 0.
REQ-018 SHALL arbitrate round-robin: search starts at rr_ptr, ascending with wrap 3->0; after a grant to channel k, rr_ptr <= (k+1) mod 4; rr_ptr holds when no grant.
REQ-019 SHALL assert det_valid for one cycle, with det_ch = k, in the cycle after channel k consumed the completing 1 from S4 (latency 1).
REQ-020 SHALL increment counter[k] on each detection, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHALL on clr_ch[i]: state[i] <= S0, counter[i] <= 0; if channel i is granted the same cycle, grant still asserts (bit consumed), clear wins, no detection reported, no increment.
REQ-022 SHALL leave state and counter of a channel untouched while chan_en[i] = 0; re-enable resumes from the saved state.
REQ-023 SHALL keep req/din of non-granted channels unconsumed; requester holds req until granted.
REQ-024 SHALL make cnt_out reflect counter values as of the last clock edge (no bypass of same-cycle increment).

Reset
REQ-025 SHALL on reset = 1, asynchronously: all channel states S0, all counters 0, rr_ptr 0, det_valid 0, det_ch 0.
REQ-026 SHALL keep grant = 0 while reset = 1, regardless of req.
REQ-027 SHALL, on reset asserted mid-sequence, discard partial matches; a sequence in flight is not detected after release unless fully re-sent.

Verification
REQ-028 SHALL cover: channel 0 only, enabled, bits 1,1,0,0,1 -> grant=0001 each cycle, det_valid=1 det_ch=0 one cycle after the fifth bit, counter[0]=1.
REQ-029 SHALL cover overlap: channel 1 bits 1,1,0,0,1,1,0,0,1 -> two detections (after bits 5 and 9), counter[1]=2.
REQ-030 SHALL cover arbitration: req=1111 held for 8 cycles, rr_ptr=0 -> grant sequence 0001,0010,0100,1000,0001,...; each channel advances every 4th cycle; interleaved 11001 on all channels -> 4 detections, det_ch 0,1,2,3 in order.
REQ-031 SHALL cover clear collision: channel 2 in S4, din=1, clr_ch[2]=1 same cycle as grant -> no det_valid, state S0, counter[2]=0.
REQ-032 SHALL cover saturation and masking: CNT_W=2, 5 detections on channel 3 -> cnt_out=3; chan_en[3]=0 with req[3]=1 -> grant[3]=0, state held.
REQ-033 SHALL cover async reset: reset asserted mid-clock after 1,1,0,0 on channel 0 -> immediate clear of outputs; then single 1 -> no detection.
